// File: rtl/asy_counter_initiator.sv
// Synchronous initiator for the asynchronous counter's four-phase start/ack handshake.
// Synchronises ack, captures the bundled count, and reports done/timeout/txn count.
module asy_counter_initiator #(
   parameter int unsigned SYNC_STAGES = 2,  // ack synchroniser depth, at least 2
   parameter int unsigned TIMEOUT_W   = 8,  // timeout fires after 2^TIMEOUT_W-1 cycles in one phase
   parameter int unsigned CLR_CYCLES  = 2   // clr_n_o low time for a clear request, at least 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go_i,
   input  logic       clr_req_i,
   input  logic       ack_i,
   input  logic [3:0] dout_i,
   output logic       start_o,
   output logic       clr_n_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [3:0] data_o,
   output logic       timeout_o,
   output logic [7:0] txn_cnt_o
);

   localparam int unsigned DATA_W = 4;
   localparam int unsigned TXN_W  = 8;
   localparam int unsigned CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;
   localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_REQ,
      S_RELEASE,
      S_ABORT
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
   logic                   start_q, start_d;
   logic                   clr_n_q, clr_n_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   timeout_q, timeout_d;
   logic [TXN_W-1:0]       txn_q, txn_d;
   logic [TIMEOUT_W-1:0]   tmo_q, tmo_d, tmo_inc;
   logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;

   // Ack synchroniser: ack_i shifts in at the bottom, ack_s is the oldest stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

   // State and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b0;
         clr_n_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         data_q    <= '0;
         timeout_q <= 1'b0;
         txn_q     <= '0;
         tmo_q     <= '0;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         clr_n_q   <= clr_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         data_q    <= data_d;
         timeout_q <= timeout_d;
         txn_q     <= txn_d;
         tmo_q     <= tmo_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next-state and next-output logic for the handshake sequencer.
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      clr_n_d   = 1'b1;
      done_d    = 1'b0;
      data_d    = data_q;
      timeout_d = timeout_q;
      txn_d     = txn_q;
      tmo_d     = tmo_q;
      clr_cnt_d = clr_cnt_q;
      tmo_inc   = TIMEOUT_W'(tmo_q + 1'b1);

      unique case (state_q)
         S_IDLE: begin
            start_d = 1'b0;
            // A request is held off while the counter still shows ack from before.
            if (go_i && !ack_s) begin
               timeout_d = 1'b0;
               tmo_d     = '0;
               if (clr_req_i) begin
                  state_d   = S_CLEAR;
                  clr_n_d   = 1'b0;
                  clr_cnt_d = '0;
               end else begin
                  state_d = S_REQ;
                  start_d = 1'b1;
               end
            end
         end

         S_CLEAR: begin
            start_d = 1'b0;
            if (clr_cnt_q == CLR_LAST) begin
               state_d = S_REQ;
            end else begin
               clr_n_d   = 1'b0;
               clr_cnt_d = CLR_W'(clr_cnt_q + 1'b1);
            end
         end

         S_REQ: begin
            // Coming from CLEAR, start rises one cycle after clr_n_o returns high;
            // the timeout only runs once start is actually asserted.
            if (!start_q) begin
               start_d = 1'b1;
            end else if (ack_s) begin
               data_d  = dout_i;
               start_d = 1'b0;
               tmo_d   = '0;
               state_d = S_RELEASE;
            end else if (tmo_inc == TMO_MAX) begin
               timeout_d = 1'b1;
               start_d   = 1'b0;
               state_d   = S_ABORT;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         S_RELEASE: begin
            start_d = 1'b0;
            if (!ack_s) begin
               done_d  = 1'b1;
               txn_d   = TXN_W'(txn_q + 1'b1);
               state_d = S_IDLE;
            end else if (tmo_inc == TMO_MAX) begin
               timeout_d = 1'b1;
               state_d   = S_ABORT;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         S_ABORT: begin
            start_d = 1'b0;
            if (!ack_s) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            start_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign start_o   = start_q;
   assign clr_n_o   = clr_n_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign data_o    = data_q;
   assign timeout_o = timeout_q;
   assign txn_cnt_o = txn_q;

endmodule

// File: tb/tb_asy_counter_initiator.sv
// Self-checking bench for asy_counter_initiator with a behavioural counter responder.
module tb_asy_counter_initiator;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned TIMEOUT_W   = 8;
   localparam int unsigned CLR_CYCLES  = 2;
   localparam int          TMO_CYCLES  = (1 << TIMEOUT_W) - 1;
   localparam int          WAIT_LIMIT  = 400;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       go_i;
   logic       clr_req_i;
   logic       ack_i;
   logic [3:0] dout_i;
   logic       start_o;
   logic       clr_n_o;
   logic       busy_o;
   logic       done_o;
   logic [3:0] data_o;
   logic       timeout_o;
   logic [7:0] txn_cnt_o;

   int checks = 0;
   int errors = 0;

   // Responder controls, written only by the main sequence.
   bit         resp_en;
   bit         resp_inc;
   bit         resp_rand_dly;
   int         resp_delay;
   logic [3:0] resp_base;
   bit         man_en;
   bit         man_ack;

   // Reference state: expected transaction count and last captured value.
   logic [7:0] exp_txn;
   logic [3:0] exp_data;

   asy_counter_initiator #(
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT_W  (TIMEOUT_W),
      .CLR_CYCLES (CLR_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .go_i     (go_i),
      .clr_req_i(clr_req_i),
      .ack_i    (ack_i),
      .dout_i   (dout_i),
      .start_o  (start_o),
      .clr_n_o  (clr_n_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .data_o   (data_o),
      .timeout_o(timeout_o),
      .txn_cnt_o(txn_cnt_o)
   );

   always #5 clk = ~clk;

   // Counter model: raise ack (with data) some cycles after start rises, drop it after start falls.
   initial begin : responder
      int cnt;
      int cur_dly;
      int n_acks;
      cnt = 0;
      cur_dly = 3;
      n_acks = 0;
      ack_i = 1'b0;
      dout_i = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!resp_rand_dly) cur_dly = resp_delay;
         if (!resp_inc) n_acks = 0;
         if (man_en) begin
            ack_i = man_ack;
            cnt = 0;
         end else if (!resp_en) begin
            cnt = 0;
         end else if (start_o === 1'b1 && ack_i === 1'b0) begin
            cnt++;
            if (cnt >= cur_dly) begin
               dout_i = resp_inc ? 4'(resp_base + 4'(n_acks)) : resp_base;
               ack_i = 1'b1;
               n_acks++;
               cnt = 0;
               if (resp_rand_dly) cur_dly = $urandom_range(4, 1);
            end
         end else if (start_o === 1'b0 && ack_i === 1'b1) begin
            cnt++;
            if (cnt >= cur_dly) begin
               ack_i = 1'b0;
               dout_i = 4'($urandom);
               cnt = 0;
               if (resp_rand_dly) cur_dly = $urandom_range(4, 1);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Waits (bounded) for a done pulse, sampling on the falling edge.
   task automatic wait_done(output bit seen, output int cycles);
      seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < WAIT_LIMIT) begin
         @(negedge clk);
         cycles++;
         if (done_o === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({start_o, clr_n_o, busy_o, done_o, timeout_o} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_ctrl: start/clr_n/busy/done/timeout got %b exp 01000",
                  {start_o, clr_n_o, busy_o, done_o, timeout_o});
      end
      checks++;
      if (data_o !== 4'h0 || txn_cnt_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: data %h txn %h exp 0 0", data_o, txn_cnt_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit seen;
      int n;
      int extra;
      resp_en = 1'b1;
      resp_delay = 3;
      resp_base = 4'hA;
      go_i = 1'b1;
      clr_req_i = 1'b0;
      @(negedge clk);
      go_i = 1'b0;
      checks++;
      if (start_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_start: start %b busy %b exp 1 1", start_o, busy_o);
      end
      wait_done(seen, n);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL basic_done: no done within %0d cycles", n);
      end
      exp_txn = 8'(exp_txn + 8'd1);
      exp_data = 4'hA;
      checks++;
      if (data_o !== exp_data || txn_cnt_o !== exp_txn) begin
         errors++;
         $display("FAIL basic_result: data %h txn %0d exp %h %0d", data_o, txn_cnt_o, exp_data, exp_txn);
      end
      extra = 0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy: busy %b exp 0", busy_o);
      end
      repeat (10) begin
         @(negedge clk);
         if (done_o !== 1'b0) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL basic_single_done: extra done cycles %0d exp 0", extra);
      end
   endtask

   task automatic test_clear();
      bit seen;
      int n;
      int low;
      resp_base = 4'(4'h1 + 4'($urandom_range(13, 0)));
      go_i = 1'b1;
      clr_req_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      clr_req_i = 1'b0;
      low = 0;
      while (clr_n_o === 1'b0 && low < 20) begin
         low++;
         @(negedge clk);
      end
      checks++;
      if (low != int'(CLR_CYCLES)) begin
         errors++;
         $display("FAIL clear_width: clr_n low %0d cycles exp %0d", low, CLR_CYCLES);
      end
      checks++;
      if (start_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_start_early: start %b exp 0 when clr_n returns", start_o);
      end
      @(negedge clk);
      checks++;
      if (start_o !== 1'b1 || clr_n_o !== 1'b1) begin
         errors++;
         $display("FAIL clear_start: start %b clr_n %b exp 1 1", start_o, clr_n_o);
      end
      wait_done(seen, n);
      exp_txn = 8'(exp_txn + 8'd1);
      exp_data = resp_base;
      checks++;
      if (!seen || data_o !== exp_data || txn_cnt_o !== exp_txn) begin
         errors++;
         $display("FAIL clear_result: done %b data %h txn %0d exp 1 %h %0d",
                  seen, data_o, txn_cnt_o, exp_data, exp_txn);
      end
   endtask

   task automatic test_timeout();
      bit seen;
      int n;
      int dn;
      resp_en = 1'b0;
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      checks++;
      if (start_o !== 1'b1) begin
         errors++;
         $display("FAIL tmo_start: start %b exp 1", start_o);
      end
      n = 0;
      dn = 0;
      while (timeout_o !== 1'b1 && n < TMO_CYCLES + 20) begin
         @(negedge clk);
         n++;
         if (done_o === 1'b1) dn++;
      end
      checks++;
      if (n != TMO_CYCLES || start_o !== 1'b0) begin
         errors++;
         $display("FAIL tmo_timing: timeout after %0d cycles start %b exp %0d 0", n, start_o, TMO_CYCLES);
      end
      checks++;
      if (dn != 0 || txn_cnt_o !== exp_txn || data_o !== exp_data) begin
         errors++;
         $display("FAIL tmo_side: done %0d txn %0d data %h exp 0 %0d %h", dn, txn_cnt_o, data_o, exp_txn, exp_data);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || timeout_o !== 1'b1) begin
         errors++;
         $display("FAIL tmo_abort: busy %b timeout %b exp 0 1", busy_o, timeout_o);
      end
      resp_en = 1'b1;
      resp_base = 4'($urandom);
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      checks++;
      if (timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL tmo_clear: timeout %b exp 0 after accepted go", timeout_o);
      end
      wait_done(seen, n);
      exp_txn = 8'(exp_txn + 8'd1);
      exp_data = resp_base;
      checks++;
      if (!seen || data_o !== exp_data || txn_cnt_o !== exp_txn || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL tmo_recover: done %b data %h txn %0d timeout %b exp 1 %h %0d 0",
                  seen, data_o, txn_cnt_o, timeout_o, exp_data, exp_txn);
      end
   endtask

   task automatic test_ack_held();
      bit seen;
      int n;
      int hold;
      int bad;
      resp_en = 1'b0;
      man_en = 1'b1;
      man_ack = 1'b1;
      repeat (4) @(negedge clk);
      go_i = 1'b1;
      hold = $urandom_range(8, 3);
      bad = 0;
      repeat (hold) begin
         @(negedge clk);
         if (start_o !== 1'b0 || busy_o !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL held_idle: %0d cycles left IDLE while ack high, exp 0", bad);
      end
      man_ack = 1'b0;
      n = 0;
      while (ack_i !== 1'b0 && n < 5) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (start_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      go_i = 1'b0;
      checks++;
      if (n != int'(SYNC_STAGES) + 1) begin
         errors++;
         $display("FAIL held_release: start after %0d edges from ack fall exp %0d", n, SYNC_STAGES + 1);
      end
      resp_base = 4'($urandom);
      man_en = 1'b0;
      resp_en = 1'b1;
      wait_done(seen, n);
      exp_txn = 8'(exp_txn + 8'd1);
      exp_data = resp_base;
      checks++;
      if (!seen || data_o !== exp_data || txn_cnt_o !== exp_txn) begin
         errors++;
         $display("FAIL held_result: done %b data %h txn %0d exp 1 %h %0d",
                  seen, data_o, txn_cnt_o, exp_data, exp_txn);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int n;
      resp_en = 1'b1;
      resp_base = 4'h3;
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      n = 0;
      while (!(start_o === 1'b0 && busy_o === 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (data_o !== 4'h3 || ack_i !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_release: data %h ack %b exp 3 1", data_o, ack_i);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({start_o, clr_n_o, busy_o, done_o, timeout_o, data_o, txn_cnt_o} !== {5'b01000, 4'h0, 8'h00}) begin
         errors++;
         $display("FAIL rstmid_async: start %b clr_n %b busy %b done %b tmo %b data %h txn %h exp 0 1 0 0 0 0 0",
                  start_o, clr_n_o, busy_o, done_o, timeout_o, data_o, txn_cnt_o);
      end
      man_en = 1'b1;
      man_ack = 1'b0;
      resp_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_txn = 8'h00;
      exp_data = 4'h0;
      @(negedge clk);
      man_en = 1'b0;
      resp_en = 1'b1;
      resp_base = 4'hC;
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      checks++;
      if (start_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_restart: start %b exp 1", start_o);
      end
      wait_done(seen, n);
      exp_txn = 8'(exp_txn + 8'd1);
      exp_data = 4'hC;
      checks++;
      if (!seen || data_o !== exp_data || txn_cnt_o !== exp_txn) begin
         errors++;
         $display("FAIL rstmid_result: done %b data %h txn %0d exp 1 %h %0d",
                  seen, data_o, txn_cnt_o, exp_data, exp_txn);
      end
   endtask

   task automatic test_back_to_back();
      bit         seen;
      int         n;
      logic [3:0] base;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_txn = 8'h00;
      base = 4'($urandom);
      resp_base = base;
      resp_inc = 1'b1;
      resp_rand_dly = 1'b1;
      resp_en = 1'b1;
      @(negedge clk);
      go_i = 1'b1;
      clr_req_i = 1'b0;
      for (int i = 0; i < 256; i++) begin
         wait_done(seen, n);
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL b2b_done: txn %0d no done within %0d cycles", i, n);
            break;
         end
         exp_txn = 8'(exp_txn + 8'd1);
         exp_data = 4'(base + 4'(i));
         checks++;
         if (data_o !== exp_data || txn_cnt_o !== exp_txn) begin
            errors++;
            $display("FAIL b2b_result: txn %0d data %h cnt %0d exp %h %0d", i, data_o, txn_cnt_o, exp_data, exp_txn);
         end
         if (i == 255) begin
            go_i = 1'b0;
         end else begin
            @(negedge clk);
            checks++;
            if (start_o !== 1'b1) begin
               errors++;
               $display("FAIL b2b_restart: txn %0d start %b exp 1 one cycle after done", i, start_o);
            end
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (txn_cnt_o !== 8'h00 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_wrap: txn %0d busy %b exp 0 0", txn_cnt_o, busy_o);
      end
      resp_inc = 1'b0;
      resp_rand_dly = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      go_i = 1'b0;
      clr_req_i = 1'b0;
      resp_en = 1'b0;
      resp_inc = 1'b0;
      resp_rand_dly = 1'b0;
      resp_delay = 3;
      resp_base = 4'h0;
      man_en = 1'b0;
      man_ack = 1'b0;
      exp_txn = 8'h00;
      exp_data = 4'h0;
      test_reset();
      test_basic();
      test_clear();
      test_timeout();
      test_ack_held();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/asy_counter_initiator.md
Name: asy_counter_initiator

Overview:
- Synchronous initiator for the asynchronous counter's start/ack four-phase (return-to-zero) handshake.
- Drives start and clear-n toward the counter, synchronises its asynchronous ack, and captures the bundled 4-bit count when ack is seen high.
- Reports completion, timeout and a transaction count to the host logic on the same clock.

Parameters:
- SYNC_STAGES, 2, number of flops in the ack synchroniser (minimum 2).
- TIMEOUT_W, 8, timeout counter width; timeout fires after 2^TIMEOUT_W-1 cycles waiting in one phase.
- CLR_CYCLES, 2, number of cycles clr_n_o is held low for a clear request (minimum 1).

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- go_i  in  1  host request for one transaction; sampled only in IDLE.
- clr_req_i  in  1  sampled with go_i; when 1, a clear pulse precedes the request.
- ack_i  in  1  asynchronous ack from the counter.
- dout_i  in  4  asynchronous bundled count; stable whenever ack_i is high.
- start_o  out  1  handshake request toward the counter (registered).
- clr_n_o  out  1  active-low clear toward the counter (registered).
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle pulse when a transaction completes.
- data_o  out  4  last captured count.
- timeout_o  out  1  sticky timeout flag.
- txn_cnt_o  out  8  completed-transaction counter.

Behaviour:
- Reset: state IDLE, all sync flops 0, start_o=0, clr_n_o=1, busy_o=0, done_o=0, data_o=0, timeout_o=0, txn_cnt_o=0. Reset applied mid-transaction forces the same values immediately.
- ack_s is ack_i delayed through SYNC_STAGES flops. dout_i is sampled directly, and only while ack_s=1. By then it has been stable for at least SYNC_STAGES cycles.
- IDLE:
  - go_i=1 and ack_s=0 accepts the request: clear timeout_o and reset the timeout counter.
  - If clr_req_i=1, go to CLEAR. Otherwise go to REQ, with start_o=1 on the next cycle.
  - go_i=1 while ack_s=1 is held off; the block stays in IDLE until ack_s=0.
- CLEAR: clr_n_o=0 for exactly CLR_CYCLES cycles, then clr_n_o=1 and go to REQ. The timeout counter is not running in CLEAR.
- REQ:
  - start_o=1 and the timeout counter increments each cycle.
  - On ack_s=1: data_o<=dout_i, start_o<=0, reset the timeout counter, go to RELEASE.
- RELEASE:
  - start_o=0 and the timeout counter increments each cycle.
  - On ack_s=0: done_o=1 for one cycle, txn_cnt_o+1 (wraps 255->0), go to IDLE.
- Timeout: in REQ or RELEASE, when the counter reaches 2^TIMEOUT_W-1 the block sets timeout_o=1 and forces start_o=0, then goes to ABORT. There is no done_o, txn_cnt_o is unchanged, and data_o keeps its previous value.
- ABORT: wait for ack_s=0 (no timeout), then go to IDLE. timeout_o stays 1 until the next accepted go_i.
- busy_o is registered and equals (next state != IDLE).
- Latency, SYNC_STAGES=2 and responder acking immediately:
  - go_i at edge 0 gives start_o=1 after edge 1.
  - ack_i rising before edge k gives ack_s=1 after edge k+1 (SYNC_STAGES edges). Capture and start_o=0 occur after edge k+2.
  - done_o follows ack_i falling by the same SYNC_STAGES+1 edges.
- Back-to-back: with go_i held high, the next transaction is accepted on the first IDLE cycle after done_o.
- go_i and clr_req_i are ignored outside IDLE.

Test Plan:
- Reset, then go_i=1 (clr_req_i=0), with a responder model that raises ack_i 3 cycles after start_o rises with dout_i=4'hA, and drops ack_i 3 cycles after start_o falls. Required: start_o rises 1 cycle after go_i; data_o=4'hA; one done_o pulse; txn_cnt_o=1; busy_o low after done_o.
- go_i with clr_req_i=1, CLR_CYCLES=2. Required: clr_n_o low for exactly 2 cycles, start_o rises on the cycle after clr_n_o returns to 1, and the transaction completes normally.
- Responder never acks. Required: timeout_o=1 and start_o=0 exactly 255 cycles after start_o rose (TIMEOUT_W=8); no done_o; txn_cnt_o unchanged. A following successful transaction clears timeout_o.
- ack_i held high at go_i. Required: block stays in IDLE with start_o=0 until ack_i falls plus SYNC_STAGES cycles, then starts.
- Assert rst_n=0 during RELEASE. Required: all outputs return to reset values asynchronously, and after release go_i starts a fresh transaction.
- 256 back-to-back transactions with go_i held high and dout_i incrementing. Required: each data_o matches its dout_i, and txn_cnt_o wraps to 0.
